// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module     : uart_rx_fifo
//  Description: UART receiver with a 2-flop input synchroniser, configurable
//               data width and stop bits, runtime parity selection and an
//               output FIFO that carries per-word frame/parity error flags.
//               The FIFO is drained through a valid/ready handshake.
//  Options    : `define UART_RX_MAJORITY_EN selects 3-sample majority voting
//               around each bit centre (decision one clock later).
//  Revision   : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_n,
    input  logic                          i_Enable,
    input  logic                          i_Rx_Serial,
    input  logic [1:0]                    i_Parity_Mode,
    output logic                          o_Rx_DV,
    input  logic                          i_Rx_Ready,
    output logic [DATA_BITS-1:0]          o_Rx_Byte,
    output logic                          o_Frame_Err,
    output logic                          o_Parity_Err,
    output logic                          o_Overrun,
    output logic                          o_Busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W  = $clog2(DATA_BITS);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNTF_W = c_PTR_W + 1;
    localparam int c_ENT_W  = DATA_BITS + 2;
    localparam int c_MID    = (CLKS_PER_BIT - 1) / 2;

    localparam logic [c_CNT_W-1:0]  c_LAST_CNT  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(DATA_BITS - 1);
    localparam logic                c_LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [c_CNTF_W-1:0] c_DEPTH     = c_CNTF_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Synchroniser: the serial line is asynchronous to i_Clock
    // ------------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_s;

    // Two-flop synchroniser, idles high; unaffected by i_Enable
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_Rx_Serial;
            r_rx_s    <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Bit sampler. The decision point in START is the bit centre (or one
    // clock after it when voting); every later bit is one full period on.
    // ------------------------------------------------------------------------
    logic w_bit;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [c_CNT_W-1:0] c_START_PT = c_CNT_W'(c_MID + 1);

    logic [1:0] r_hist;

    // Keep the two previous synchronised samples for the 3-way vote
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], r_rx_s};
        end
    end

    assign w_bit = (r_hist[1] & r_hist[0]) |
                   (r_hist[1] & r_rx_s)    |
                   (r_hist[0] & r_rx_s);
`else
    localparam logic [c_CNT_W-1:0] c_START_PT = c_CNT_W'(c_MID);

    assign w_bit = r_rx_s;
`endif

    // ------------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------------
    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_IDX_W-1:0]     r_idx;
    logic                   r_stop_idx;
    logic [DATA_BITS-1:0]   r_data;
    logic [1:0]             r_par_mode;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_push;
    logic [c_ENT_W-1:0]     r_push_word;

    logic w_par_en;
    logic w_ferr_nxt;

    assign w_par_en   = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);
    assign w_ferr_nxt = r_ferr | ~w_bit;

    // Frame decoder: start validation, data shift-in, parity, stop checks
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_stop_idx  <= 1'b0;
            r_data      <= '0;
            r_par_mode  <= 2'b00;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_push      <= 1'b0;
            r_push_word <= '0;
        end else if (!i_Enable) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_push     <= 1'b0;
        end else begin
            r_push <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (r_cnt == c_START_PT) begin
                        r_cnt <= '0;
                        if (!w_bit) begin
                            r_state    <= S_DATA;
                            r_par_mode <= i_Parity_Mode;
                            r_idx      <= '0;
                            r_stop_idx <= 1'b0;
                            r_perr     <= 1'b0;
                            r_ferr     <= 1'b0;
                        end else begin
                            // Line went back high: a glitch, not a start bit
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (r_cnt == c_LAST_CNT) begin
                        r_cnt  <= '0;
                        r_data <= {w_bit, r_data[DATA_BITS-1:1]};
                        if (r_idx == c_LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= w_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                S_PARITY: begin
                    if (r_cnt == c_LAST_CNT) begin
                        r_cnt   <= '0;
                        // Even: XOR of data and parity must be 0; odd: 1
                        r_perr  <= (^r_data) ^ w_bit ^ (r_par_mode == 2'b10);
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (r_cnt == c_LAST_CNT) begin
                        r_cnt  <= '0;
                        r_ferr <= w_ferr_nxt;
                        if (r_stop_idx == c_LAST_STOP) begin
                            r_push      <= 1'b1;
                            r_push_word <= {r_perr, w_ferr_nxt, r_data};
                            r_state     <= S_WAIT_IDLE;
                        end else begin
                            r_stop_idx <= r_stop_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                S_WAIT_IDLE: begin
                    // A held-low line (break) must not start another frame
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO with registered head entry
    // ------------------------------------------------------------------------
    logic [c_ENT_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_CNTF_W-1:0] r_count;
    logic [c_ENT_W-1:0]  r_head;
    logic                r_dv;
    logic                r_overrun;

    logic                w_pop;
    logic                w_full;
    logic                w_wr_en;
    logic                w_drop;
    logic [c_CNTF_W-1:0] w_count_nxt;
    logic [c_PTR_W-1:0]  w_rd_nxt;
    logic [c_PTR_W-1:0]  w_wr_nxt;
    logic [c_ENT_W-1:0]  w_head_nxt;

    assign w_pop       = r_dv & i_Rx_Ready;
    assign w_full      = (r_count == c_DEPTH);
    assign w_wr_en     = r_push & (~w_full | w_pop);
    assign w_drop      = r_push & w_full & ~w_pop;
    assign w_count_nxt = r_count + c_CNTF_W'(w_wr_en) - c_CNTF_W'(w_pop);
    assign w_rd_nxt    = r_rd_ptr + c_PTR_W'(w_pop);
    assign w_wr_nxt    = r_wr_ptr + c_PTR_W'(w_wr_en);

    // Next head: bypass the incoming word when it lands in the head slot
    always_comb begin
        w_head_nxt = '0;
        if (w_count_nxt != '0) begin
            if (w_wr_en && (w_rd_nxt == r_wr_ptr)) begin
                w_head_nxt = r_push_word;
            end else begin
                w_head_nxt = r_mem[w_rd_nxt];
            end
        end
    end

    // Storage array; contents are only observed through the head register
    always_ff @(posedge i_Clock) begin
        if (i_Enable && w_wr_en) begin
            r_mem[r_wr_ptr] <= r_push_word;
        end
    end

    // Pointers, occupancy, head register and sticky overrun
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_head    <= '0;
            r_dv      <= 1'b0;
            r_overrun <= 1'b0;
        end else if (!i_Enable) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_head    <= '0;
            r_dv      <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_rd_ptr <= w_rd_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_count  <= w_count_nxt;
            r_head   <= w_head_nxt;
            r_dv     <= (w_count_nxt != '0);
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_Rx_DV      = r_dv;
    assign o_Rx_Byte    = r_head[DATA_BITS-1:0];
    assign o_Frame_Err  = r_head[DATA_BITS];
    assign o_Parity_Err = r_head[DATA_BITS+1];
    assign o_Overrun    = r_overrun;
    assign o_Busy       = (r_state != S_IDLE);
    assign o_Fifo_Count = r_count;

endmodule
`default_nettype wire
